// File: rtl/mem_wb_buf.sv
// rtl/mem_wb_buf.sv - MEM/WB elastic FIFO buffer with misalignment rewrite and flush
// Optional MEM_WB_BUF_PERF_EN builds the saturating stall/drop counters.
module mem_wb_buf #(
    parameter int                 DEPTH           = 2,
    parameter int                 ADDR_W          = 30,
    parameter int                 DATA_W          = 32,
    parameter int                 REG_ADDR_W      = 5,
    parameter int                 CTRL_OP_W       = 2,
    parameter int                 EXP_W           = 3,
    parameter logic [EXP_W-1:0]   MISS_ALIGN_CODE = EXP_W'(4)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_miss_align,
    input  logic [ADDR_W-1:0]              in_pc,
    input  logic                           in_br_flag,
    input  logic [CTRL_OP_W-1:0]           in_ctrl_op,
    input  logic [REG_ADDR_W-1:0]          in_dst_addr,
    input  logic                           in_gpr_we_,
    input  logic [EXP_W-1:0]               in_exp_code,
    input  logic [DATA_W-1:0]              in_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ADDR_W-1:0]              out_pc,
    output logic                           out_br_flag,
    output logic [CTRL_OP_W-1:0]           out_ctrl_op,
    output logic [REG_ADDR_W-1:0]          out_dst_addr,
    output logic                           out_gpr_we_,
    output logic [EXP_W-1:0]               out_exp_code,
    output logic [DATA_W-1:0]              out_out,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [15:0]                    stall_cnt,
    output logic [15:0]                    drop_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = ADDR_W + 1 + CTRL_OP_W + REG_ADDR_W + 1 + EXP_W + DATA_W;
    // Empty entry: everything zero except the active-low write enable.
    localparam logic [ENT_W-1:0] EMPTY_ENTRY = ENT_W'(1) << (EXP_W + DATA_W);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] head;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = count_q;

    always_comb begin
        wr_entry = {in_pc, in_br_flag, in_ctrl_op, in_dst_addr, in_gpr_we_, in_exp_code, in_out};
        if (in_miss_align) begin
            wr_entry = {in_pc, in_br_flag, {CTRL_OP_W{1'b0}}, {REG_ADDR_W{1'b0}}, 1'b1,
                        MISS_ALIGN_CODE, {DATA_W{1'b0}}};
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: the outputs are masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head = out_valid ? mem_q[rd_ptr_q] : EMPTY_ENTRY;
    assign {out_pc, out_br_flag, out_ctrl_op, out_dst_addr, out_gpr_we_, out_exp_code, out_out} = head;

`ifdef MEM_WB_BUF_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        drop_sum    = {1'b0, drop_cnt_q} + 17'(count_q);
        if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush) begin
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`else
    assign stall_cnt = 16'h0;
    assign drop_cnt  = 16'h0;
`endif

endmodule

// File: tb/tb_mem_wb_buf.sv
// tb/tb_mem_wb_buf.sv - scoreboard bench for mem_wb_buf (DEPTH = 2)
module tb_mem_wb_buf;

`ifdef MEM_WB_BUF_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [29:0] pc;
        logic        br;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exp;
        logic [31:0] dat;
    } pl_t;

    localparam pl_t EMPTY = '{pc: 30'h0, br: 1'b0, ctrl: 2'h0, dst: 5'h0, we_: 1'b1, exp: 3'h0, dat: 32'h0};

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_miss_align;
    logic [29:0] in_pc;
    logic        in_br_flag;
    logic [1:0]  in_ctrl_op;
    logic [4:0]  in_dst_addr;
    logic        in_gpr_we_;
    logic [2:0]  in_exp_code;
    logic [31:0] in_out;
    logic        out_valid, out_ready;
    logic [29:0] out_pc;
    logic        out_br_flag;
    logic [1:0]  out_ctrl_op;
    logic [4:0]  out_dst_addr;
    logic        out_gpr_we_;
    logic [2:0]  out_exp_code;
    logic [31:0] out_out;
    logic [1:0]  count;
    logic [15:0] stall_cnt, drop_cnt;

    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;
    pl_t  cur_exp;
    pl_t  exp_q[$];
    pl_t  act;

    mem_wb_buf #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_miss_align(in_miss_align),
        .in_pc(in_pc), .in_br_flag(in_br_flag), .in_ctrl_op(in_ctrl_op),
        .in_dst_addr(in_dst_addr), .in_gpr_we_(in_gpr_we_), .in_exp_code(in_exp_code),
        .in_out(in_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_br_flag(out_br_flag), .out_ctrl_op(out_ctrl_op),
        .out_dst_addr(out_dst_addr), .out_gpr_we_(out_gpr_we_), .out_exp_code(out_exp_code),
        .out_out(out_out), .count(count), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    assign act = '{pc: out_pc, br: out_br_flag, ctrl: out_ctrl_op, dst: out_dst_addr,
                   we_: out_gpr_we_, exp: out_exp_code, dat: out_out};

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic miss, input pl_t p, input pl_t e);
        in_valid      = v;
        in_miss_align = miss;
        in_pc         = p.pc;
        in_br_flag    = p.br;
        in_ctrl_op    = p.ctrl;
        in_dst_addr   = p.dst;
        in_gpr_we_    = p.we_;
        in_exp_code   = p.exp;
        in_out        = p.dat;
        cur_exp       = e;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, EMPTY, EMPTY);
    endtask

    // Scoreboard monitor: sampled mid-cycle, ahead of the edge that commits the handshake.
    always @(negedge clk) begin
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", {98'h0, act}, 128'h0 | 128'hFFFF_FFFF);
                end else begin
                    check("payload", {54'h0, act}, {54'h0, exp_q.pop_front()});
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    pl_t v;
    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        idle();
        step(); step();
        reset = 1'b0;
        step();
        check("rst_in_ready",  in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_count",     count, 0);
        check("rst_gpr_we_",   out_gpr_we_, 1);
        check("rst_exp_code",  out_exp_code, 0);
        check("rst_payload",   act, EMPTY);
        check("rst_stall",     stall_cnt, 0);
        check("rst_drop",      drop_cnt, 0);

        // Fill with WB stalled, then drain.
        v = '{pc: 30'h100, br: 1'b0, ctrl: 2'h0, dst: 5'd1, we_: 1'b0, exp: 3'h0, dat: 32'h11};
        drive(1'b1, 1'b0, v, v);
        step();
        v = '{pc: 30'h104, br: 1'b0, ctrl: 2'h0, dst: 5'd2, we_: 1'b0, exp: 3'h0, dat: 32'h22};
        drive(1'b1, 1'b0, v, v);
        step();
        idle();
        repeat (3) step();
        check("full_count",    count, 2);
        check("full_in_ready", in_ready, 0);
        check("full_out_pc",   out_pc, 30'h100);
        check("full_stall",    stall_cnt, PERF ? 4 : 0);
        out_ready = 1'b1;
        step();
        check("drain_out_pc",  out_pc, 30'h104);
        check("drain_count",   count, 1);
        step();
        check("empty_valid",   out_valid, 0);
        check("empty_payload", act, EMPTY);
        check("empty_stall",   stall_cnt, PERF ? 4 : 0);

        // Misalignment rewrite, then a verbatim entry.
        v = '{pc: 30'h200, br: 1'b1, ctrl: 2'h1, dst: 5'd7, we_: 1'b0, exp: 3'h0, dat: 32'hDEADBEEF};
        drive(1'b1, 1'b1, v,
              '{pc: 30'h200, br: 1'b1, ctrl: 2'h0, dst: 5'd0, we_: 1'b1, exp: 3'h4, dat: 32'h0});
        step();
        check("miss_exp_code", out_exp_code, 4);
        check("miss_gpr_we_",  out_gpr_we_, 1);
        v = '{pc: 30'h204, br: 1'b1, ctrl: 2'h3, dst: 5'd9, we_: 1'b0, exp: 3'h2, dat: 32'hCAFE0001};
        drive(1'b1, 1'b0, v, v);
        step();
        idle();
        step(); step();

        // Streaming: one entry per cycle, occupancy stays at one.
        for (int i = 0; i < 8; i++) begin
            v = '{pc: 30'h300 + 30'(4*i), br: 1'(i), ctrl: 2'(i), dst: 5'(i+3), we_: 1'(i>>1),
                  exp: 3'h0, dat: 32'h1000 * 32'(i+1)};
            drive(1'b1, 1'b0, v, v);
            step();
            check("stream_count", count, 1);
        end
        idle();
        step();
        check("stream_drained", count, 0);

        // Flush a full buffer together with a push.
        out_ready = 1'b0;
        v = '{pc: 30'h400, br: 1'b0, ctrl: 2'h0, dst: 5'd4, we_: 1'b0, exp: 3'h0, dat: 32'h44};
        drive(1'b1, 1'b0, v, v);
        step();
        v.pc = 30'h404;
        drive(1'b1, 1'b0, v, v);
        step();
        check("pre_flush_count", count, 2);
        v.pc = 30'h408;
        drive(1'b1, 1'b0, v, v);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        check("flush_count", count, 0);
        check("flush_valid", out_valid, 0);
        check("flush_drop",  drop_cnt, PERF ? 2 : 0);

        // Flush a partly filled buffer while a push would otherwise be accepted.
        v.pc = 30'h40C;
        drive(1'b1, 1'b0, v, v);
        step();
        check("pre_flush2_count", count, 1);
        v.pc = 30'h410;
        drive(1'b1, 1'b0, v, v);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        check("flush2_count", count, 0);
        check("flush2_drop",  drop_cnt, PERF ? 3 : 0);
        step(); step();
        check("flush2_valid", out_valid, 0);

        // Reset beats a same-cycle push.
        v.pc = 30'h500;
        drive(1'b1, 1'b0, v, v);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        check("rst2_count",    count, 0);
        check("rst2_valid",    out_valid, 0);
        check("rst2_in_ready", in_ready, 1);
        check("rst2_payload",  act, EMPTY);
        check("rst2_stall",    stall_cnt, 0);
        check("rst2_drop",     drop_cnt, 0);
        step(); step();

        check("sb_leftover", exp_q.size(), 0);
        check("pop_total",   pops, 12);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_buf.md
# mem_wb_buf

Parametrised MEM/WB stage buffer for the CPU pipeline. Replaces the single-entry stall/flush register with a DEPTH-entry elastic FIFO carrying the MEM-stage payload under a valid/ready handshake, so that a stalled WB consumer no longer has to back-pressure MEM every cycle. Misalignment rewriting is applied on entry. Flush discards every buffered entry in one cycle.

## Interface
Parameters:
- DEPTH, 2, buffered entries (1..16); full throughput requires DEPTH >= 2
- ADDR_W, 30, program-counter width
- DATA_W, 32, result data width
- REG_ADDR_W, 5, GPR address width
- CTRL_OP_W, 2, control-register op width; NOP = 0
- EXP_W, 3, exception code width; no-exception = 0
- MISS_ALIGN_CODE, 3'h4, exception code injected on misalignment

Ports:
- clk  in  1  clock
- reset  in  1  reset; one clock, reset is synchronous and active-high
- flush  in  1  discard all entries and the same-cycle push
- in_valid  in  1  payload valid
- in_ready  out  1  buffer can accept (registered: count < DEPTH)
- in_miss_align  in  1  misalignment detected for this payload
- in_pc  in  ADDR_W  program counter
- in_br_flag  in  1  branch flag
- in_ctrl_op  in  CTRL_OP_W  control-register op
- in_dst_addr  in  REG_ADDR_W  GPR write address
- in_gpr_we_  in  1  GPR write enable, active low
- in_exp_code  in  EXP_W  exception code
- in_out  in  DATA_W  memory-access result
- out_valid  out  1  head entry valid (count != 0)
- out_ready  in  1  WB accepts head
- out_pc, out_br_flag, out_ctrl_op, out_dst_addr, out_gpr_we_, out_exp_code, out_out  out  as inputs  head-entry payload
- count  out  $clog2(DEPTH+1)  occupied entries
- stall_cnt  out  16  saturating count of cycles with out_valid && !out_ready
- drop_cnt  out  16  saturating count of entries discarded by flush

## Operation
- Storage: circular buffer. Write pointer and read pointer each wrap from DEPTH-1 to 0. count tracks occupancy.
- Push happens when in_valid && in_ready && !flush. Pop happens when out_valid && out_ready && !flush.
- Push and pop in the same cycle:
  - both pointers advance;
  - count is unchanged.
- Full and empty boundaries:
  - Full: in_ready = 0, so no push is possible.
  - Empty: out_valid = 0, and out_ready is ignored.
- Misalignment rewrite on push (when in_miss_align = 1):
  - store pc, br_flag and the valid bit unchanged;
  - force ctrl_op = NOP, dst_addr = 0, gpr_we_ = 1, exp_code = MISS_ALIGN_CODE, out = 0.
- When in_miss_align = 0, the payload is stored verbatim.
- Empty-buffer outputs: out_pc = 0, out_br_flag = 0, out_ctrl_op = 0, out_dst_addr = 0, out_gpr_we_ = 1, out_exp_code = 0, out_out = 0. No stale data appears on the outputs.
- Flush:
  - pointers and count go to 0;
  - any push or pop in the same cycle is suppressed;
  - drop_cnt increases by the pre-flush count.
- Priority: reset > flush > push/pop.
- Reset: pointers = 0, count = 0, in_ready = 1, out_valid = 0, all counters = 0. Payload outputs take the empty values listed above.
- Reset or flush asserted mid-stream loses all entries. No partial state survives.

## Timing
- Latency: a payload pushed at edge N is visible on out_* with out_valid = 1 after edge N (zero-wait in cycle N+1). There is no bypass from in_* to out_*.
- in_ready depends only on registered count. There is no combinational path from out_ready to in_ready.
- out_* is a mux on registered storage indexed by the read pointer. It has no combinational path from in_*.
- With DEPTH >= 2 and out_ready held at 1, throughput is one entry per cycle.
- With DEPTH = 1, throughput drops to one entry every two cycles.
- Counters update on the clock edge and saturate at 16'hFFFF.

## Configuration
- MEM_WB_BUF_PERF_EN:
  - Defined: stall_cnt and drop_cnt are implemented as described above.
  - Undefined: both ports are tied to 16'h0 and no counter flops are built.
- Handshake, FIFO and rewrite behaviour are identical in both builds.

## Test plan
- Reset, then idle → in_ready = 1, out_valid = 0, count = 0, out_gpr_we_ = 1, out_exp_code = 0.
- DEPTH = 2; push pc = 0x100 and pc = 0x104 with out_ready = 0 → count = 2, in_ready = 0, out_pc = 0x100. Then set out_ready = 1 → out_pc = 0x104 next cycle, then empty. stall_cnt equals the held cycles.
- Push with in_miss_align = 1, pc = 0x200, in_gpr_we_ = 0, in_ctrl_op = 1, in_out = 0xDEADBEEF → out_pc = 0x200, out_exp_code = 4, out_gpr_we_ = 1, out_ctrl_op = 0, out_dst_addr = 0, out_out = 0.
- Continuous push with out_ready = 1 for 8 cycles → 8 entries delivered in order, one per cycle, and count stays at 1.
- Buffer full (count = 2), then flush together with in_valid = 1 → count = 0 and out_valid = 0 next cycle. The pushed entry is never delivered. drop_cnt = 2 (0 when MEM_WB_BUF_PERF_EN is undefined).
- Push with reset asserted in the same cycle → count = 0, out_valid = 0, and all outputs hold their reset values.
